// File: rtl/sap_mem_defs.sv
// Shared definitions for the SAP memory subsystem: FSM states, request op codes and the
// default f189 strobe timing reused by the fetch sequencer.
package sap_mem_defs;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StSetup = 3'd1,
        StWrite = 3'd2,
        StHold  = 3'd3,
        StRead  = 3'd4,
        StResp  = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        OpRead        = 2'b00,
        OpWrite       = 2'b01,
        OpWriteVerify = 2'b10,
        OpReserved    = 2'b11
    } op_e;

    localparam int unsigned F189SetupCycles = 1;
    localparam int unsigned F189PulseCycles = 2;
    localparam int unsigned F189ReadCycles  = 1;

    function automatic logic op_is_write(op_e op);
        return (op == OpWrite) || (op == OpWriteVerify);
    endfunction

    // Counter width able to hold (n - 1) for the longest timed phase.
    function automatic int unsigned phase_cnt_width(int unsigned a, int unsigned b,
                                                    int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/ram_programmer_if.sv
// Request, response and f189 RAM pin bundle for ram_programmer.
interface ram_programmer_if;

    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [3:0] req_addr;
    logic [3:0] req_data;

    logic [3:0] ram_a;
    logic [3:0] ram_d;
    logic       ram_cs;
    logic       ram_we;
    logic [3:0] ram_o;

    logic       rsp_valid;
    logic [3:0] rsp_data;
    logic       rsp_error;

    // Environment side: requester plus the RAM's read-data pins.
    modport master (
        output req_valid, req_op, req_addr, req_data, ram_o,
        input  req_ready, ram_a, ram_d, ram_cs, ram_we, rsp_valid, rsp_data, rsp_error
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_data, ram_o,
        output req_ready, ram_a, ram_d, ram_cs, ram_we, rsp_valid, rsp_data, rsp_error
    );

endinterface

// File: rtl/phase_counter.sv
// Loadable down-counter with terminal-count flag; a phase lasts (load value + 1) cycles.
module phase_counter #(
    parameter int unsigned Width = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [Width-1:0] value,
    output logic             done
);

    logic [Width-1:0] count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= value;
        end else if (count_q != '0) begin
            count_q <= count_q - Width'(1);
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/ram_programmer.sv
// Write-side controller for the f189 16x4 RAM: sequences active-low cs/we with address and
// data setup/hold, and returns read or write-verify results as a one-cycle response.
module ram_programmer
    import sap_mem_defs::*;
#(
    parameter int unsigned SETUP_CYCLES = F189SetupCycles,
    parameter int unsigned PULSE_CYCLES = F189PulseCycles,
    parameter int unsigned READ_CYCLES  = F189ReadCycles,
    parameter bit          INVERT_READ  = 1'b1
) (
    input logic             clk,
    input logic             reset,
    ram_programmer_if.slave bus
);

    localparam int unsigned CntWidth = phase_cnt_width(SETUP_CYCLES, PULSE_CYCLES, READ_CYCLES);

    state_e state_q, state_d;
    op_e    op_q;
    logic [3:0] addr_q, data_q;
    logic [3:0] rsp_data_q, rsp_data_d;
    logic       rsp_error_q, rsp_error_d;
    logic       cs_q, cs_d;
    logic       we_q, we_d;

    logic                cnt_load;
    logic [CntWidth-1:0] cnt_value;
    logic                cnt_done;
    logic                accept;
    logic [3:0]          sampled;

    assign accept  = (state_q == StIdle) && bus.req_valid;
    assign sampled = INVERT_READ ? ~bus.ram_o : bus.ram_o;

    phase_counter #(
        .Width (CntWidth)
    ) u_phase_counter (
        .clk   (clk),
        .reset (reset),
        .load  (cnt_load),
        .value (cnt_value),
        .done  (cnt_done)
    );

    always_comb begin
        state_d     = state_q;
        cnt_load    = 1'b0;
        cnt_value   = '0;
        rsp_data_d  = rsp_data_q;
        rsp_error_d = rsp_error_q;

        case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    cnt_load = 1'b1;
                    if (op_is_write(op_e'(bus.req_op))) begin
                        state_d   = StSetup;
                        cnt_value = CntWidth'(SETUP_CYCLES - 1);
                    end else begin
                        // Reserved op falls through to a plain read.
                        state_d   = StRead;
                        cnt_value = CntWidth'(READ_CYCLES - 1);
                    end
                end
            end
            StSetup: begin
                if (cnt_done) begin
                    state_d   = StWrite;
                    cnt_load  = 1'b1;
                    cnt_value = CntWidth'(PULSE_CYCLES - 1);
                end
            end
            StWrite: begin
                if (cnt_done) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (op_q == OpWriteVerify) begin
                    state_d   = StRead;
                    cnt_load  = 1'b1;
                    cnt_value = CntWidth'(READ_CYCLES - 1);
                end else begin
                    state_d     = StResp;
                    rsp_data_d  = data_q;
                    rsp_error_d = 1'b0;
                end
            end
            StRead: begin
                if (cnt_done) begin
                    state_d     = StResp;
                    rsp_data_d  = sampled;
                    rsp_error_d = (op_q == OpWriteVerify) && (sampled != data_q);
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Strobes are registered from the next state so they change only on clock edges.
    always_comb begin
        cs_d = !((state_d == StSetup) || (state_d == StWrite) ||
                 (state_d == StHold)  || (state_d == StRead));
        we_d = (state_d != StWrite);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            op_q        <= OpRead;
            addr_q      <= '0;
            data_q      <= '0;
            rsp_data_q  <= '0;
            rsp_error_q <= 1'b0;
            cs_q        <= 1'b1;
            we_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            rsp_data_q  <= rsp_data_d;
            rsp_error_q <= rsp_error_d;
            cs_q        <= cs_d;
            we_q        <= we_d;
            if (accept) begin
                op_q   <= op_e'(bus.req_op);
                addr_q <= bus.req_addr;
                data_q <= bus.req_data;
            end
        end
    end

    assign bus.req_ready = (state_q == StIdle);
    assign bus.ram_a     = addr_q;
    assign bus.ram_d     = data_q;
    assign bus.ram_cs    = cs_q;
    assign bus.ram_we    = we_q;
    assign bus.rsp_valid = (state_q == StResp);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_error = rsp_error_q;

endmodule

// File: tb/tb_ram_programmer.sv
// Self-checking bench for ram_programmer: f189 pin model plus a memory-level reference model
// driven by directed and randomized requests.
module tb_ram_programmer;
    import sap_mem_defs::*;

    localparam int unsigned SetupCycles = 2;
    localparam int unsigned PulseCycles = 2;
    localparam int unsigned ReadCycles  = 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ram_programmer_if bus ();

    ram_programmer #(
        .SETUP_CYCLES (SetupCycles),
        .PULSE_CYCLES (PulseCycles),
        .READ_CYCLES  (ReadCycles),
        .INVERT_READ  (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // f189 pin model: stores while cs/we are low, drives complemented data while selected.
    logic [3:0] ram_mem [16];
    logic       corrupt;

    always_comb begin
        bus.ram_o = bus.ram_cs ? 4'hF : (~ram_mem[bus.ram_a] ^ (corrupt ? 4'h1 : 4'h0));
    end

    always @(negedge clk) begin
        if (!bus.ram_cs && !bus.ram_we) ram_mem[bus.ram_a] <= bus.ram_d;
    end

    // Reference: what the memory should hold after each completed request.
    logic [3:0] ref_mem [16];
    bit         ref_known [16];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cs"}, 32'(bus.ram_cs), 32'd1);
        check({tag, "_we"}, 32'(bus.ram_we), 32'd1);
        check({tag, "_a"}, 32'(bus.ram_a), 32'd0);
        check({tag, "_d"}, 32'(bus.ram_d), 32'd0);
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, "_rsp_data"}, 32'(bus.rsp_data), 32'd0);
        check({tag, "_rsp_error"}, 32'(bus.rsp_error), 32'd0);
        check({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
    endtask

    // One request from IDLE through its response; returns at the negedge after RESP.
    task automatic run_req(input logic [1:0] op, input logic [3:0] addr, input logic [3:0] data,
                           input bit bad, input bit scramble);
        bit          is_wr, verify, seen, prev_we_low;
        int unsigned lat_exp, lat, we_low, cs_low;
        logic [3:0]  exp_data;
        logic        exp_err;

        is_wr   = (op == 2'b01) || (op == 2'b10);
        verify  = (op == 2'b10);
        lat_exp = is_wr ? SetupCycles + PulseCycles + 1 + (verify ? ReadCycles : 0) : ReadCycles;
        exp_err = verify && bad;
        if (!is_wr)      exp_data = ref_mem[addr];
        else if (verify) exp_data = bad ? (data ^ 4'h1) : data;
        else             exp_data = data;

        @(posedge clk);
        #1;
        check("ready_idle", 32'(bus.req_ready), 32'd1);
        corrupt       = bad;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_data  = data;
        @(posedge clk);
        #1;
        if (!scramble) bus.req_valid = 1'b0;

        seen = 0; lat = 0; we_low = 0; cs_low = 0; prev_we_low = 0;
        for (int k = 0; k < 24 && !seen; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                seen = 1;
                lat  = k;
            end else begin
                check("ready_busy", 32'(bus.req_ready), 32'd0);
                if (!bus.ram_we) begin
                    we_low++;
                    check("we_needs_cs", 32'(bus.ram_cs), 32'd0);
                end
                if (prev_we_low && bus.ram_we) check("we_rise_before_cs", 32'(bus.ram_cs), 32'd0);
                if (!bus.ram_cs) begin
                    cs_low++;
                    check("ad_stable", 32'({bus.ram_a, bus.ram_d}), 32'({addr, data}));
                end
                prev_we_low = !bus.ram_we;
            end
            if (scramble) begin
                bus.req_addr = 4'($urandom);
                bus.req_data = 4'($urandom);
            end
        end

        check("rsp_seen", 32'(seen), 32'd1);
        if (seen) begin
            check("latency", lat, lat_exp);
            check("we_low_cycles", we_low, is_wr ? PulseCycles : 0);
            check("cs_low_cycles", cs_low, lat_exp);
            check("resp_strobes", 32'({bus.ram_cs, bus.ram_we}), 32'b11);
            if (is_wr || ref_known[addr]) check("rsp_data", 32'(bus.rsp_data), 32'(exp_data));
            check("rsp_error", 32'(bus.rsp_error), 32'(exp_err));
        end
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("rsp_one_cycle", 32'(bus.rsp_valid), 32'd0);
        check("ready_after", 32'(bus.req_ready), 32'd1);
        corrupt = 1'b0;

        if (is_wr) begin
            ref_mem[addr]   = data;
            ref_known[addr] = 1;
        end
    endtask

    task automatic reset_during_write(input logic [3:0] addr, input logic [3:0] data);
        bit hit;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b01;
        bus.req_addr  = addr;
        bus.req_data  = data;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        hit = 0;
        for (int k = 0; k < 12 && !hit; k++) begin
            @(negedge clk);
            if (!bus.ram_we) hit = 1;
        end
        check("write_pulse_reached", 32'(hit), 32'd1);
        reset = 1'b1;
        #1;
        check("rst_we_async", 32'(bus.ram_we), 32'd1);
        check("rst_cs_async", 32'(bus.ram_cs), 32'd1);
        check("rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        ref_known[addr] = 0;
    endtask

    initial begin
        logic [1:0] op;
        logic [3:0] a, d;
        bit         bad;

        reset         = 1'b1;
        corrupt       = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_addr  = 4'h0;
        bus.req_data  = 4'h0;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i]   = 4'h0;
            ref_known[i] = 0;
        end
        #12;
        check_reset_outputs("por");
        @(negedge clk);
        reset = 1'b0;

        run_req(2'b01, 4'h2, 4'hC, 0, 0);
        run_req(2'b00, 4'h2, 4'h0, 0, 0);
        run_req(2'b10, 4'hF, 4'h5, 0, 0);
        run_req(2'b10, 4'hF, 4'h5, 1, 0);
        run_req(2'b01, 4'h4, 4'hA, 0, 1);
        run_req(2'b00, 4'h4, 4'h3, 0, 1);

        reset_during_write(4'h7, 4'h9);
        run_req(2'b01, 4'h7, 4'h6, 0, 0);
        run_req(2'b00, 4'h7, 4'h0, 0, 0);

        for (int i = 0; i < 16; i++) begin
            a = 4'(i);
            run_req(2'b01, a, ~a, 0, 0);
        end
        for (int i = 0; i < 16; i++) begin
            a = 4'(i);
            run_req(2'b00, a, 4'h0, 0, 0);
        end
        run_req(2'b11, 4'h3, 4'h0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            op  = 2'($urandom_range(0, 3));
            a   = 4'($urandom);
            d   = 4'($urandom);
            bad = (op == 2'b10) && ($urandom_range(0, 3) == 0);
            run_req(op, a, d, bad, $urandom_range(0, 1) == 1);
        end

        @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_outputs("idle_rst");
        @(negedge clk);
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
